// File: rtl/mem_bist_master.sv
// mem_bist_master: writes a seed-derived pattern to every word, reads it back and counts mismatches.
// Latency: 3*DEPTH cycles from the accepted start edge to the done pulse when ready is held high.
// Backpressure: request outputs hold steady while ready is low; each read waits one cycle for rdata.
module mem_bist_master #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  input  logic                  invert,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] L_LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   L_ERR_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   L_ERR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] L_IDX_ONE = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [WIDTH-1:0]      r_seed;
  logic                  r_invert;
  logic [ADDR_WIDTH:0]   r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  r_pass;

  logic [WIDTH-1:0]      w_pattern;
  logic                  w_last;
  logic                  w_mismatch;
  logic [ADDR_WIDTH:0]   w_err_count_next;

  // Expected word for the current index; the same value is written and later compared.
  assign w_pattern  = (r_seed + WIDTH'(r_idx)) ^ {WIDTH{r_invert}};
  assign w_last     = (r_idx == L_LAST);
  assign w_mismatch = (r_state == S_CMP) && (rdata != w_pattern);
  // Saturate so the count can never wrap past DEPTH.
  assign w_err_count_next = (w_mismatch && (r_err_count != L_ERR_MAX)) ?
                            (r_err_count + L_ERR_ONE) : r_err_count;

  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;

  // Next-state decode and memory request outputs; requests are pure state decode so they stay stable while ready is low.
  always_comb begin
    w_state_next = r_state;
    valid        = 1'b0;
    wr_rd        = 1'b0;
    addr         = '0;
    wdata        = '0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_WR;
      end
      S_WR: begin
        valid = 1'b1;
        wr_rd = 1'b1;
        addr  = r_idx;
        wdata = w_pattern;
        if (ready && w_last) w_state_next = S_RD;
      end
      S_RD: begin
        valid = 1'b1;
        addr  = r_idx;
        if (ready) w_state_next = S_CMP;
      end
      S_CMP: begin
        w_state_next = w_last ? S_DONE : S_RD;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register plus index, captured test settings and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_idx            <= '0;
      r_seed           <= '0;
      r_invert         <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_pass           <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seed           <= seed;
            r_invert         <= invert;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
            r_idx            <= '0;
          end
        end
        S_WR: begin
          if (ready) r_idx <= w_last ? '0 : (r_idx + L_IDX_ONE);
        end
        S_CMP: begin
          r_err_count <= w_err_count_next;
          if (w_mismatch && (r_err_count == '0)) r_first_err_addr <= r_idx;
          r_idx <= w_last ? '0 : (r_idx + L_IDX_ONE);
          // Result is ready together with the done pulse, including this final compare.
          if (w_last) r_pass <= (w_err_count_next == '0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_master.sv
// tb_mem_bist_master: drives mem_bist_master against a behavioural memory with stalls and corrupted reads.
// Latency: checks the done pulse arrives 3*DEPTH cycles after start when ready is held high.
// Backpressure: memory model stalls ready in fixed and random patterns and checks request stability.
module tb_mem_bist_master;
  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef struct {
    logic [15:0]   seed;
    logic          inv;
    int            mode;     // 0: ready high, 1: 3-cycle stall every other txn, 2: random ready
    logic [63:0]   cmask;    // addresses whose read data is corrupted
    int            extra;    // cycle after start to pulse a stray start, -1 for none
    int            lat;      // expected start-to-done cycles, 0 to skip
    logic [AW:0]   err;
    logic [AW-1:0] first;
    logic          pass;
    logic [15:0]   m0;
    logic [15:0]   m63;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, start, invert, valid, wr_rd, ready, busy, done, pass;
  logic [WIDTH-1:0] seed, wdata, rdata;
  logic [AW-1:0]    addr, first_err_addr;
  logic [AW:0]      err_count;

  always #5 clk = ~clk;

  mem_bist_master #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .invert(invert),
    .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ready(ready), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [63:0]      cmask = '0;
  logic [15:0]      exp_seed = '0;
  logic             exp_inv = 1'b0;
  int mode = 0, stall = 0, txn_no = 0;
  int done_cnt = 0, done_cyc = 0, exp_pos = 0, bad_txn = 0, stab_bad = 0;
  logic          got_pass;
  logic [AW:0]   got_err;
  logic [AW-1:0] got_first;
  logic          held_v = 1'b0, held_wr;
  logic [AW-1:0] held_a;
  logic [WIDTH-1:0] held_d;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Pattern word i: seed plus i, complemented when inversion is selected.
  function automatic logic [WIDTH-1:0] pat(input int i);
    logic [WIDTH-1:0] v;
    v = exp_seed + i[WIDTH-1:0];
    if (exp_inv) v = ~v;
    return v;
  endfunction

  // Memory model and monitor: samples the bus on the falling edge, answers after the rising edge.
  always begin : mem_model
    logic hs_s, rd_s, vld_s;
    logic [AW-1:0] a_s;
    @(negedge clk);
    hs_s  = valid && ready && !rst;
    rd_s  = hs_s && !wr_rd;
    vld_s = valid && !rst;
    a_s   = addr;
    if (held_v && (valid !== 1'b1 || wr_rd !== held_wr || addr !== held_a || wdata !== held_d))
      stab_bad++;
    held_v  = valid && !ready && !rst;
    held_wr = wr_rd;
    held_a  = addr;
    held_d  = wdata;
    if (hs_s) begin
      if (exp_pos < DEPTH) begin
        if (!(wr_rd === 1'b1 && addr === AW'(exp_pos) && wdata === pat(exp_pos))) bad_txn++;
      end else if (exp_pos < 2*DEPTH) begin
        if (!(wr_rd === 1'b0 && addr === AW'(exp_pos - DEPTH) && wdata === '0)) bad_txn++;
      end else begin
        bad_txn++;
      end
      exp_pos++;
      if (wr_rd) mem[addr] = wdata;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      got_pass  = pass;
      got_err   = err_count;
      got_first = first_err_addr;
    end
    @(posedge clk);
    #1;
    rdata = rd_s ? (mem[a_s] ^ (cmask[a_s] ? 16'h5A5A : 16'h0000)) : WIDTH'($urandom);
    if (hs_s) begin
      txn_no++;
      if (mode == 1 && (txn_no % 2) == 1) stall = 3;
    end else if (vld_s && stall > 0) begin
      stall--;
    end
    case (mode)
      1:       ready = (stall == 0);
      2:       ready = ($urandom_range(0, 2) != 0);
      default: ready = 1'b1;
    endcase
  end

  task automatic arm(input vec_t v);
    mode = v.mode; cmask = v.cmask; exp_seed = v.seed; exp_inv = v.inv;
    exp_pos = 0; bad_txn = 0; stab_bad = 0; done_cnt = 0; txn_no = 0; stall = 0;
    ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
  endtask

  task automatic run_test(input string nm, input vec_t v);
    int sc, n;
    arm(v);
    seed = v.seed; invert = v.inv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed = WIDTH'($urandom); invert = 1'(($urandom));
    sc = cyc;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      if (n == v.extra) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({nm, " done_seen"}, done_cnt, 1);
    if (v.lat > 0) chk({nm, " latency"}, done_cyc - sc, v.lat);
    chk({nm, " err_count"}, got_err, v.err);
    chk({nm, " first_err_addr"}, got_first, v.first);
    chk({nm, " pass"}, got_pass, v.pass);
    chk({nm, " bad_txns"}, bad_txn, 0);
    chk({nm, " txn_total"}, exp_pos, 2*DEPTH);
    chk({nm, " stall_stability"}, stab_bad, 0);
    chk({nm, " mem0"}, mem[0], v.m0);
    chk({nm, " mem63"}, mem[63], v.m63);
    repeat (5) @(posedge clk);
    #1;
    chk({nm, " single_done"}, done_cnt, 1);
    chk({nm, " idle_busy"}, busy, 0);
    chk({nm, " hold_result"}, {pass, err_count, first_err_addr}, {v.pass, v.err, v.first});
  endtask

  vec_t vt[7];
  vec_t rv;

  initial begin
    vt[0] = '{16'h1234, 1'b0, 0, 64'h0, -1, 192, 7'd0, 6'd0, 1'b1, 16'h1234, 16'h1273};
    vt[1] = '{16'h1234, 1'b0, 1, 64'h0, -1, 0, 7'd0, 6'd0, 1'b1, 16'h1234, 16'h1273};
    vt[2] = '{16'hABCD, 1'b0, 0, 64'h0000_0100_0000_0020, -1, 192, 7'd2, 6'd5, 1'b0, 16'hABCD, 16'hAC0C};
    vt[3] = '{16'h0000, 1'b1, 0, 64'h0, -1, 192, 7'd0, 6'd0, 1'b1, 16'hFFFF, 16'hFFC0};
    vt[4] = '{16'hFFF0, 1'b0, 2, 64'h8000_0000_0000_0000, -1, 0, 7'd1, 6'd63, 1'b0, 16'hFFF0, 16'h002F};
    vt[5] = '{16'h5555, 1'b1, 1, 64'h1, -1, 0, 7'd1, 6'd0, 1'b0, 16'hAAAA, 16'hAA6B};
    vt[6] = '{16'h0000, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5, 192, 7'd64, 6'd0, 1'b0, 16'h0000, 16'h003F};

    rst = 1'b1; start = 1'b1; seed = 16'hFFFF; invert = 1'b1; ready = 1'b1; rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {valid, wr_rd, addr, wdata, busy, done, pass, err_count, first_err_addr}, 0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("start_ignored_in_reset", busy, 0);

    for (int i = 0; i < 7; i++) run_test($sformatf("vec%0d", i), vt[i]);

    // Abort after ten write handshakes, with start held during reset.
    rv = '{16'h1111, 1'b0, 0, 64'h0, -1, 0, 7'd0, 6'd0, 1'b1, 16'h1111, 16'h1150};
    arm(rv);
    seed = rv.seed; invert = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 200 && exp_pos < 10; n++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid wr_handshakes", exp_pos, 10);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid valid", valid, 0);
    chk("rst_mid outputs", {valid, wr_rd, addr, wdata, busy, done, pass, err_count, first_err_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (250) @(posedge clk);
    #1;
    chk("rst_mid no_done", done_cnt, 0);
    chk("rst_mid no_more_txns", exp_pos, 10);
    chk("rst_mid idle", busy, 0);
    run_test("after_rst", rv);

    // Randomized runs checked against the plain-arithmetic result model.
    for (int t = 0; t < 6; t++) begin
      logic [15:0] tmp;
      int cnt;
      rv.seed = 16'($urandom);
      rv.inv  = 1'($urandom_range(0, 1));
      rv.mode = $urandom_range(0, 2);
      rv.extra = -1;
      rv.lat  = (rv.mode == 0) ? 3*DEPTH : 0;
      cnt = 0;
      rv.first = '0;
      for (int b = 0; b < DEPTH; b++) begin
        rv.cmask[b] = ($urandom_range(0, 7) == 0);
        if (rv.cmask[b]) begin
          if (cnt == 0) rv.first = AW'(b);
          cnt++;
        end
      end
      rv.err  = 7'(cnt);
      rv.pass = (cnt == 0);
      rv.m0   = rv.inv ? ~rv.seed : rv.seed;
      tmp     = rv.seed + 16'd63;
      rv.m63  = rv.inv ? ~tmp : tmp;
      run_test($sformatf("rand%0d", t), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
